// File: rtl/if_stage.sv
// RV32I instruction fetch stage.
// Owns the PC, presents a combinational byte address to instruction memory,
// and captures the returned word (or a NOP on a fault) into the IF/ID register.
// Once a faulting entry is captured, fetch stops until a redirect arrives.
module if_stage #(
   parameter int          DEPTH    = 8192,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH)-1:0] imem_addr,
   input  logic [31:0]              imem_instr,
   output logic                     id_valid,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_pc4,
   output logic [31:0]              id_instr,
   output logic [1:0]               id_fault,
   output logic [31:0]              fetch_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] MEM_END  = 32'(DEPTH);
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [1:0]  fault;
   logic        load;

   // Memory address is the low bits of the PC; the range check uses the full PC.
   assign imem_addr = pc[AW-1:0];
   assign pc4       = pc + 32'd4;

   // Classify the current PC; misalignment wins over out-of-range.
   always_comb begin
      fault = 2'b00;
      if (pc[1:0] != 2'b00)
         fault = 2'b01;
      else if (pc >= MEM_END)
         fault = 2'b10;
   end

   // A new entry is captured when fetching, IF/ID is free or draining, and no redirect.
   assign load = (state == RUN) && (!id_valid || id_ready) && !redirect;

   // PC, fetch state and IF/ID register; priority rst > redirect > load > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         state       <= RUN;
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_pc4      <= '0;
         id_instr    <= '0;
         id_fault    <= 2'b00;
         fetch_count <= '0;
      end else if (redirect) begin
         // Kill whatever IF/ID holds, even if decode is stalled.
         pc       <= redirect_pc;
         state    <= RUN;
         id_valid <= 1'b0;
      end else if (load) begin
         id_valid    <= 1'b1;
         id_pc       <= pc;
         id_pc4      <= pc4;
         id_instr    <= (fault != 2'b00) ? NOP : imem_instr;
         id_fault    <= fault;
         fetch_count <= fetch_count + 32'd1;
         if (fault == 2'b00) begin
            pc <= pc4;
         end else begin
            state <= FAULT;
         end
      end else if (id_ready) begin
         // Not loading (fault stop): decode consumes the held entry.
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage with a behavioural fetch model.
module tb_if_stage;

   localparam int DEPTH = 8192;
   localparam int AW    = $clog2(DEPTH);
   localparam int WORDS = DEPTH / 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          id_ready = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_instr;
   logic          id_valid;
   logic [31:0]   id_pc, id_pc4, id_instr, fetch_count;
   logic [1:0]    id_fault;

   logic [31:0] mem [WORDS];

   int checks = 0;
   int errors = 0;

   // model of the fetch stage
   logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr, m_cnt;
   logic        m_stopped, m_valid;
   logic [1:0]  m_fault;

   if_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
      .id_fault(id_fault), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr[AW-1:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural reference: one clock edge of the fetch rules.
   task automatic model_edge(input logic r, input logic rd, input logic [31:0] rpc,
                             input logic rdy);
      logic [1:0] f;
      if (r) begin
         m_pc = 32'h0; m_stopped = 1'b0; m_valid = 1'b0;
         m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0; m_fault = 0; m_cnt = 0;
      end else if (rd) begin
         m_pc = rpc; m_valid = 1'b0; m_stopped = 1'b0;
      end else if (!m_stopped && (!m_valid || rdy)) begin
         if (m_pc % 4 != 0)                 f = 2'b01;
         else if (m_pc >= 32'(DEPTH))       f = 2'b10;
         else                               f = 2'b00;
         m_valid    = 1'b1;
         m_id_pc    = m_pc;
         m_id_pc4   = m_pc + 4;
         m_id_instr = (f != 0) ? 32'h13 : mem[m_pc / 4];
         m_fault    = f;
         m_cnt      = m_cnt + 1;
         if (f != 0) m_stopped = 1'b1;
         else        m_pc = m_pc + 4;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
   endtask

   // Compare every DUT output with the model.
   task automatic compare_all();
      chk("imem_addr",   32'(imem_addr), 32'(m_pc[AW-1:0]));
      chk("id_valid",    32'(id_valid),  32'(m_valid));
      chk("id_pc",       id_pc,          m_id_pc);
      chk("id_pc4",      id_pc4,         m_id_pc4);
      chk("id_instr",    id_instr,       m_id_instr);
      chk("id_fault",    32'(id_fault),  32'(m_fault));
      chk("fetch_count", fetch_count,    m_cnt);
   endtask

   // Drive one cycle of inputs (called at negedge), advance, check at next negedge.
   task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
      rst = r; redirect = rd; redirect_pc = rpc; id_ready = rdy;
      @(posedge clk);
      model_edge(r, rd, rpc, rdy);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      logic [31:0] rpc;
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0000_1111;
      mem[3] = 32'h0000_2222;
      @(negedge clk);

      // reset state
      step(1, 0, 0, 0);
      chk("rst_valid", 32'(id_valid), 0);
      chk("rst_count", fetch_count, 0);

      // straight-line fetch
      step(0, 0, 0, 1);
      chk("t1_valid", 32'(id_valid), 1);
      chk("t1_pc0", id_pc, 32'h0);
      chk("t1_instr0", id_instr, 32'h0050_0093);
      step(0, 0, 0, 1);
      chk("t1_pc4", id_pc, 32'h4);
      chk("t1_instr1", id_instr, 32'h00A0_0113);
      chk("t1_count", fetch_count, 2);

      // decode stall freezes everything
      repeat (3) step(0, 0, 0, 0);
      chk("t2_pc_frozen", id_pc, 32'h4);
      chk("t2_cnt_frozen", fetch_count, 2);
      chk("t2_addr_frozen", 32'(imem_addr), 32'h8);
      step(0, 0, 0, 1);
      chk("t2_resume", id_pc, 32'h8);
      chk("t2_resume_instr", id_instr, 32'h0000_1111);

      // redirect while stalled
      step(0, 1, 32'h40, 0);
      chk("t3_killed", 32'(id_valid), 0);
      chk("t3_addr", 32'(imem_addr), 32'h40);
      chk("t3_cnt", fetch_count, 3);
      step(0, 0, 0, 1);
      chk("t3_pc", id_pc, 32'h40);
      chk("t3_pc4", id_pc4, 32'h44);

      // misaligned redirect
      step(0, 1, 32'h42, 1);
      step(0, 0, 0, 0);
      chk("t4_fault", 32'(id_fault), 1);
      chk("t4_nop", id_instr, 32'h13);
      step(0, 0, 0, 1);
      chk("t4_drained", 32'(id_valid), 0);
      repeat (2) step(0, 0, 0, 1);
      chk("t4_stopped_cnt", fetch_count, 5);
      step(0, 1, 32'h8, 1);
      step(0, 0, 0, 1);
      chk("t4_resume", id_pc, 32'h8);

      // out-of-range and top-of-memory crossing
      step(0, 1, 32'h2000, 1);
      step(0, 0, 0, 1);
      chk("t5_access", 32'(id_fault), 2);
      chk("t5_addr", 32'(imem_addr), 0);
      step(0, 1, 32'h1FFC, 1);
      step(0, 0, 0, 1);
      chk("t5_top_ok", 32'(id_fault), 0);
      chk("t5_top_pc", id_pc, 32'h1FFC);
      step(0, 0, 0, 1);
      chk("t5_cross", 32'(id_fault), 2);
      chk("t5_cross_pc", id_pc, 32'h2000);

      // pc+4 wrap at top of address space
      step(0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 1);
      chk("wrap_pc4", id_pc4, 32'h0);
      chk("wrap_fault", 32'(id_fault), 2);

      // reset during a stall with a valid entry
      step(0, 1, 32'h10, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("t6_valid", 32'(id_valid), 0);
      chk("t6_cnt", fetch_count, 0);
      chk("t6_addr", 32'(imem_addr), 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 4))
            0: rpc = {19'h0, 11'($urandom_range(0, WORDS - 1)), 2'b00};
            1: rpc = 32'h1FF0 + 4 * $urandom_range(0, 7);
            2: rpc = 32'($urandom_range(0, 255));
            3: rpc = $urandom;
            default: rpc = 32'hFFFF_FFF0 + 4 * $urandom_range(0, 3);
         endcase
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8), rpc,
              ($urandom_range(0, 99) < 70));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
